// File: rtl/serial_paralelo_rx_pkg.sv
// Shared PHY definitions: COM idle/alignment character and receiver state encoding.
package serial_paralelo_rx_pkg;

    localparam logic [7:0] COM_CHAR = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx_com_detect.sv
// Serial shift window: presents the 8 most recent bits (current bit as LSB) and flags a COM match.
module rx_com_detect #(
    parameter logic [7:0] COM_CHAR = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] cand,
    output logic       com_hit
);

    // Only the 7 older bits need storage; the newest bit is the live input.
    logic [6:0] sr;

    assign cand    = {sr, data_in};
    assign com_hit = (cand == COM_CHAR);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr <= 7'd0;
        end else begin
            sr <= cand[6:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: COM-based byte alignment, then non-COM byte delivery.
// Optional macro RX_BYTE_CNT_EN adds a saturating count of delivered bytes.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM_CHAR  = serial_paralelo_rx_pkg::COM_CHAR,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset_L,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        active
`ifdef RX_BYTE_CNT_EN
    ,
    output logic [15:0] rx_byte_cnt
`endif
);

    import serial_paralelo_rx_pkg::*;

    localparam logic [2:0] COM_TARGET = 3'(COM_COUNT);

    rx_state_t  state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [2:0] com_cnt, com_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       active_nxt;
    logic [7:0] cand;
    logic       com_hit;
    logic       boundary;

    rx_com_detect #(
        .COM_CHAR (COM_CHAR)
    ) u_com_detect (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .data_in (data_in),
        .cand    (cand),
        .com_hit (com_hit)
    );

    assign boundary = (bit_cnt == 3'd7);

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        com_cnt_nxt = com_cnt;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (com_hit) begin
                    bit_cnt_nxt = 3'd0;
                    com_cnt_nxt = 3'd1;
                    state_nxt   = (COM_COUNT == 1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (com_hit) begin
                        com_cnt_nxt = com_cnt + 3'd1;
                        if (com_cnt_nxt == COM_TARGET) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        com_cnt_nxt = 3'd0;
                        state_nxt   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary && !com_hit) begin
                    data_nxt  = cand;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
        active_nxt = (state_nxt == ACTIVE);
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            bit_cnt   <= 3'd0;
            com_cnt   <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            active    <= active_nxt;
        end
    end

`ifdef RX_BYTE_CNT_EN
    // Delivered-byte counter, updated on the same edge as the strobe; holds at all-ones
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            rx_byte_cnt <= 16'd0;
        end else if (valid_nxt && (rx_byte_cnt != 16'hFFFF)) begin
            rx_byte_cnt <= rx_byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Randomized bench for serial_paralelo_rx against an index-based stream model of COM alignment.
module tb_serial_paralelo_rx;

    localparam int unsigned COM_COUNT = 4;
    localparam logic [7:0]  COM       = 8'hBC;
    localparam int          MAXN      = 1024;

    logic        clk_32f;
    logic        reset_L;
    logic        data_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
`ifdef RX_BYTE_CNT_EN
    logic [15:0] rx_byte_cnt;
`endif

    serial_paralelo_rx #(
        .COM_CHAR  (COM),
        .COM_COUNT (COM_COUNT)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef RX_BYTE_CNT_EN
        ,
        .rx_byte_cnt (rx_byte_cnt)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int          checks = 0;
    int          errors = 0;
    int          nbits;
    logic        bits      [MAXN];
    logic        exp_valid [MAXN];
    logic        exp_act   [MAXN];
    logic [7:0]  exp_data  [MAXN];
    logic [15:0] exp_cnt   [MAXN];

    task automatic check(input string tag, input int cyc, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        if (nbits < MAXN) begin
            bits[nbits] = b;
            nbits++;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) push_bit(v[k]);
    endtask

    task automatic push_rand_bits(input int n);
        for (int k = 0; k < n; k++) push_bit(1'($urandom));
    endtask

    task automatic push_rand_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) push_byte(COM);
            else push_byte(8'($urandom));
        end
    endtask

    // Byte ending at stream index i (bits before the stream start read as 0).
    function automatic logic [7:0] win(input int i);
        logic [7:0] w = 8'h00;
        for (int b = i - 7; b <= i; b++) w = {w[6:0], (b >= 0) ? bits[b] : 1'b0};
        return w;
    endfunction

    // Locate the first run of COM_COUNT byte-spaced COMs; everything after it is framed data.
    task automatic build_model();
        int i = 0;
        int start_act = nbits;
        logic [7:0]  held = 8'h00;
        logic [15:0] cnt  = 16'd0;
        while (i < nbits && start_act == nbits) begin
            if (win(i) == COM) begin
                int run = 1;
                int j = i;
                while (run < int'(COM_COUNT) && j + 8 < nbits && win(j + 8) == COM) begin
                    run++;
                    j += 8;
                end
                if (run == int'(COM_COUNT)) start_act = j;
                else if (j + 8 < nbits) i = j + 9;
                else i = nbits;
            end else begin
                i++;
            end
        end
        for (int c = 0; c < nbits; c++) begin
            exp_act[c]   = (c >= start_act);
            exp_valid[c] = (c > start_act) && ((c - start_act) % 8 == 0) && (win(c) != COM);
            if (exp_valid[c]) begin
                held = win(c);
                if (cnt != 16'hFFFF) cnt++;
            end
            exp_data[c] = held;
            exp_cnt[c]  = cnt;
        end
    endtask

    task automatic run_segment(input string name);
        // Asynchronous reset taken mid-cycle, possibly mid-byte of the previous segment
        reset_L = 1'b0;
        #1;
        check({name, ":rst_data"},   -1, 16'(data_out),  16'h0000);
        check({name, ":rst_valid"},  -1, 16'(valid_out), 16'h0000);
        check({name, ":rst_active"}, -1, 16'(active),    16'h0000);
`ifdef RX_BYTE_CNT_EN
        check({name, ":rst_cnt"},    -1, rx_byte_cnt,    16'h0000);
`endif
        repeat (2) @(posedge clk_32f);
        build_model();
        @(negedge clk_32f);
        reset_L = 1'b1;
        for (int c = 0; c < nbits; c++) begin
            if (c > 0) @(negedge clk_32f);
            data_in = bits[c];
            @(posedge clk_32f);
            #1;
            check({name, ":valid"},  c, 16'(valid_out), 16'(exp_valid[c]));
            check({name, ":data"},   c, 16'(data_out),  16'(exp_data[c]));
            check({name, ":active"}, c, 16'(active),    16'(exp_act[c]));
`ifdef RX_BYTE_CNT_EN
            check({name, ":cnt"},    c, rx_byte_cnt,    exp_cnt[c]);
`endif
        end
    endtask

    initial begin
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        for (int seg = 0; seg < 24; seg++) begin
            nbits = 0;
            case (seg % 4)
                0: begin
                    push_rand_bits(int'($urandom_range(0, 15)));
                    for (int k = 0; k < int'(COM_COUNT) + int'($urandom_range(0, 2)); k++) push_byte(COM);
                    push_rand_bytes(12);
                    push_rand_bits(int'($urandom_range(0, 7)));
                    run_segment("lock_data");
                end
                1: begin
                    for (int k = 0; k < 3; k++) push_byte(COM);
                    push_byte(8'h00);
                    for (int k = 0; k < 4; k++) push_byte(COM);
                    push_byte(8'hA5);
                    push_byte(8'h3C);
                    push_byte(COM);
                    push_byte(COM);
                    push_rand_bytes(3);
                    push_rand_bits(int'($urandom_range(1, 7)));
                    run_segment("sync_break");
                end
                2: begin
                    push_rand_bits(3);
                    for (int k = 0; k < 4; k++) push_byte(COM);
                    push_byte(8'h5A);
                    push_byte(COM);
                    for (int k = 0; k < 5; k++) begin
                        push_byte(8'($urandom_range(0, 187)));
                        push_byte(COM);
                    end
                    push_rand_bits(int'($urandom_range(1, 7)));
                    run_segment("offset3");
                end
                default: begin
                    push_rand_bits(160);
                    run_segment("random");
                end
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side deserializer: the stage directly downstream of the PHY TX parallel-to-serial block, consuming its 1-bit MSB-first stream.
- Byte alignment is found by locating COM characters (8'hBC) in the idle stream.
- Link is declared active after a run of consecutive aligned COMs.
- Non-COM bytes are then delivered as 8-bit words with a one-cycle valid strobe; COM bytes are treated as idle fill and dropped.

Parameters:
COM_CHAR, 8'hBC, idle/alignment character transmitted when TX has no valid data
COM_COUNT, 4, consecutive aligned COMs required to enter ACTIVE (range 1..7)

Ports:
clk_32f  input  1  bit clock; all logic on posedge; one bit sampled per cycle
reset_L  input  1  asynchronous active-low reset
data_in  input  1  serial bit from TX, MSB first
data_out  output  8  last received non-COM byte, held between strobes
valid_out  output  1  one-cycle strobe: data_out updated this cycle
active  output  1  high while the link is aligned and in ACTIVE

Behaviour:
- Reset (reset_L low, asynchronous): state=SEARCH, shift register=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, active=0. Deassertion takes effect at the next posedge.
- Every posedge: sr <= {sr[6:0], data_in}. Candidate byte cand = {sr[6:0], data_in}, i.e. the 8 most recent bits including the current one.
- SEARCH:
  - cand is checked every cycle.
  - On cand==COM_CHAR: bit_cnt<=0, com_cnt<=1.
  - If COM_COUNT==1, go to ACTIVE; otherwise go to SYNC.
- Byte boundary (SYNC/ACTIVE): bit_cnt increments mod 8 every cycle. A boundary occurs when bit_cnt==7, with byte=cand.
- SYNC, at a boundary only:
  - byte==COM_CHAR: com_cnt++; when the new count equals COM_COUNT, go to ACTIVE and set active=1 on that edge.
  - byte!=COM_CHAR: go to SEARCH, com_cnt<=0. Detection resumes from the next cycle.
- ACTIVE, at a boundary:
  - byte!=COM_CHAR: data_out<=byte, valid_out<=1 for exactly one cycle.
  - byte==COM_CHAR: data_out holds, valid_out stays 0.
  - ACTIVE is left only by reset; there is no loss-of-sync detection.
- valid_out is 0 on every non-boundary cycle. Maximum strobe rate is 1 per 8 cycles.
- Latency: data_out/valid_out are registered on the same edge that samples the byte's LSB.
- com_cnt width is 3 bits and saturates at COM_COUNT.
- Reset mid-byte discards the partial byte. After reset, alignment restarts in SEARCH.

Optional Feature:
Macro RX_BYTE_CNT_EN.
- Defined: adds output rx_byte_cnt[15:0].
  - Cleared by reset.
  - Increments on every valid_out strobe.
  - Saturates at 16'hFFFF (no wrap).
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
Shared PHY package holds:
- COM_CHAR constant 8'hBC (also used by TX idle fill)
- state encoding localparams: SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2

No sub-module is required. The 8-bit shift register with COM comparator may be split out as rx_com_detect (inputs clk_32f, reset_L, data_in; outputs cand[7:0], com_hit).

Test Plan:
- Loop TX->RX, TX valid_in=0 from reset release -> active=1 on the LSB edge of the 4th BC, i.e. cycle 32 after the first BC bit; valid_out stays 0 throughout.
- Aligned, then TX sends 8'hA5, 8'h3C back-to-back -> valid_out pulses exactly twice, 8 cycles apart; data_out reads A5 then 3C and holds 3C afterwards.
- Stream 3 BC bytes then 8'h00 (SYNC) -> return to SEARCH, active=0; then 4 further BC bytes -> active=1.
- Serial stream offset by 3 junk bits before the BC run -> alignment locks to the true BC boundary; a subsequent 8'h5A is received exactly.
- reset_L pulsed low mid-byte while ACTIVE -> outputs cleared immediately; re-alignment needs COM_COUNT new COMs.
- RX_BYTE_CNT_EN defined, 5 data bytes interleaved with BC -> rx_byte_cnt=5. Preloaded at FFFF -> stays FFFF.
